// File: rtl/high_score_table.sv
// Top-DEPTH descending high score table persisted on SD: loads at game start, accumulates
// the running score, inserts the final score by rank and writes the table back at game over.
module high_score_table #(
  parameter int          SCORE_W   = 16,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               OVER,
  input  logic               SCORE_ADD,
  input  logic [SCORE_W-1:0] SCORE_DELTA,
  input  logic               SD_HAS_INITIALIZED,
  input  logic               SD_IS_READING,
  input  logic               SD_IS_WRITING,
  input  logic [15:0]        SD_READ_DATA,
  output logic               SD_TO_READ,
  output logic [31:0]        SD_READ_ADDRESS,
  output logic               SD_TO_WRITE,
  output logic [31:0]        SD_WRITE_ADDRESS,
  output logic [15:0]        SD_WRITE_DATA,
  input  logic [3:0]         TABLE_SEL,
  output logic [SCORE_W-1:0] TABLE_DATA,
  output logic [SCORE_W-1:0] CURRENT_SCORE,
  output logic [SCORE_W-1:0] BEST_SCORE,
  output logic [4:0]         RANK,
  output logic               READ_FINISH,
  output logic               WRITE_FINISH
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD, S_PLAY, S_INS, S_WR, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [SCORE_W-1:0] tbl_q [DEPTH];
  logic [SCORE_W-1:0] tbl_d [DEPTH];
  logic [SCORE_W-1:0] cur_q, cur_d;
  logic [4:0]         rank_q, rank_d;
  logic               to_read_q, to_read_d;
  logic               to_write_q, to_write_d;
  logic [31:0]        rd_addr_q, rd_addr_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               seen_q, seen_d;
  logic               rdf_q, rdf_d;
  logic               wrf_q, wrf_d;
  logic               rd_prev_q, wr_prev_q;

  logic [4:0]         rank_c;
  logic [SCORE_W-1:0] ins_tbl [DEPTH];
  logic [SCORE_W-1:0] nxt_word;
  logic [SCORE_W-1:0] sel_word;
  logic               last_idx;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // Rank counts entries >= the final score, so ties land below existing entries.
  always_comb begin
    rank_c   = 5'd0;
    ins_tbl  = tbl_q;
    nxt_word = '0;
    sel_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tbl_q[k] >= cur_q) rank_c = rank_c + 5'd1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (5'(k) == rank_c)     ins_tbl[k] = cur_q;
      else if (5'(k) > rank_c) ins_tbl[k] = tbl_q[(k == 0) ? 0 : k - 1];
      if (4'(k) == idx_q + 4'd1) nxt_word = tbl_q[k];
      if (4'(k) == TABLE_SEL)    sel_word = tbl_q[k];
    end
    last_idx = (idx_q == 4'(DEPTH - 1));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tbl_d      = tbl_q;
    cur_d      = cur_q;
    rank_d     = rank_q;
    to_read_d  = to_read_q;
    to_write_d = to_write_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    seen_d     = seen_q;
    rdf_d      = rdf_q;
    wrf_d      = wrf_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_WAIT;
      S_WAIT: begin
        if (SD_HAS_INITIALIZED) begin
          state_d   = S_RD;
          idx_d     = 4'd0;
          to_read_d = 1'b1;
          rd_addr_d = BASE_ADDR;
        end
      end
      S_RD: begin
        if (to_read_q && SD_IS_READING) begin
          to_read_d = 1'b0;
          seen_d    = 1'b1;
        end else if (seen_q && rd_prev_q && !SD_IS_READING) begin
          seen_d = 1'b0;
          for (int k = 0; k < DEPTH; k++) begin
            if (4'(k) == idx_q) tbl_d[k] = SD_READ_DATA[SCORE_W-1:0];
          end
          if (last_idx) begin
            rdf_d   = 1'b1;
            state_d = S_PLAY;
          end else begin
            idx_d     = idx_q + 4'd1;
            to_read_d = 1'b1;
            rd_addr_d = BASE_ADDR + 32'(idx_q + 4'd1);
          end
        end
      end
      S_PLAY: begin
        if (SCORE_ADD) cur_d = sat_add(cur_q, SCORE_DELTA);
        if (OVER) state_d = S_INS;
      end
      S_INS: begin
        rank_d = rank_c;
        if (rank_c < 5'(DEPTH)) begin
          tbl_d      = ins_tbl;
          state_d    = S_WR;
          idx_d      = 4'd0;
          to_write_d = 1'b1;
          wr_addr_d  = BASE_ADDR;
          wr_data_d  = 16'(ins_tbl[0]);
        end else begin
          state_d = S_DONE;
          wrf_d   = 1'b1;
        end
      end
      S_WR: begin
        if (to_write_q && SD_IS_WRITING) begin
          to_write_d = 1'b0;
          seen_d     = 1'b1;
        end else if (seen_q && wr_prev_q && !SD_IS_WRITING) begin
          seen_d = 1'b0;
          if (last_idx) begin
            state_d = S_DONE;
            wrf_d   = 1'b1;
          end else begin
            idx_d      = idx_q + 4'd1;
            to_write_d = 1'b1;
            wr_addr_d  = BASE_ADDR + 32'(idx_q + 4'd1);
            wr_data_d  = 16'(nxt_word);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      tbl_q      <= '{default: '0};
      cur_q      <= '0;
      rank_q     <= 5'(DEPTH);
      to_read_q  <= 1'b0;
      to_write_q <= 1'b0;
      rd_addr_q  <= 32'd0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 16'd0;
      seen_q     <= 1'b0;
      rdf_q      <= 1'b0;
      wrf_q      <= 1'b0;
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tbl_q      <= tbl_d;
      cur_q      <= cur_d;
      rank_q     <= rank_d;
      to_read_q  <= to_read_d;
      to_write_q <= to_write_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      seen_q     <= seen_d;
      rdf_q      <= rdf_d;
      wrf_q      <= wrf_d;
      rd_prev_q  <= SD_IS_READING;
      wr_prev_q  <= SD_IS_WRITING;
    end
  end

  assign SD_TO_READ       = to_read_q;
  assign SD_READ_ADDRESS  = rd_addr_q;
  assign SD_TO_WRITE      = to_write_q;
  assign SD_WRITE_ADDRESS = wr_addr_q;
  assign SD_WRITE_DATA    = wr_data_q;
  assign TABLE_DATA       = sel_word;
  assign CURRENT_SCORE    = cur_q;
  assign BEST_SCORE       = tbl_q[0];
  assign RANK             = rank_q;
  assign READ_FINISH      = rdf_q;
  assign WRITE_FINISH     = wrf_q;

endmodule
